shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
// Multi-cycle shift controller wrapped around the 8-bit logicalShiftRight barrel stage
// (3-bit ctrl, 0..7 positions per pass). Drives the stage's in/ctrl, consumes its out,
// extends it to SLL (bit-reversal around SRL) and to amounts 0..255 (clamped to 8),
// and returns the result to the ALU result path with a START/BUSY/DONE handshake.
// PARAMETERS
// WIDTH    8  datapath width; fixed to the 8-bit barrel stage, other values unsupported
// AMT_W    8  width of AMOUNT operand
// STEP_MAX 7  largest shift issued to the barrel stage in one pass (= 2**3-1)
// PORTS
// CLK     in   1      rising-edge clock
// RESET   in   1      asynchronous, active-low reset
// START   in   1      request strobe; sampled on CLK rise when state is IDLE or DONE
// OPCODE  in   2      00 SRL, 01 SLL, 10 reserved, 11 ROR (only with SHIFT_SEQ_ROR_EN)
// DATA    in   WIDTH  operand to shift
// AMOUNT  in   AMT_W  shift distance
// BUSY    out  1      high while in SHIFT state
// DONE    out  1      one-cycle pulse; RESULT valid from this cycle until next accepted START
// RESULT  out  WIDTH  registered shift result
// SH_IN   out  WIDTH  to barrel stage in
// SH_CTRL out  3      to barrel stage ctrl
// SH_OUT  in   WIDTH  from barrel stage out (combinational, same cycle)
// BEHAVIOUR
// - States IDLE, SHIFT, DONE. RESET low (any time, incl. mid-SHIFT): state IDLE, BUSY=0,
//   DONE=0, RESULT=0, SH_IN=0, SH_CTRL=0, internal acc/rem/tmp=0; aborted op gives no DONE.
// - START accepted in IDLE or DONE (back-to-back allowed); ignored in SHIFT (no queueing).
// - On accept: acc<=DATA, op<=OPCODE, rem<=min(AMOUNT,8) for SRL/SLL.
//   rem==0 or OPCODE=10 -> DONE next cycle, RESULT=DATA (passthrough, latency 1).
//   else -> SHIFT.
// - SHIFT, per cycle: step=min(rem,STEP_MAX); SH_CTRL=step;
//   SRL: SH_IN=acc, acc<=SH_OUT. SLL: SH_IN=rev(acc), acc<=rev(SH_OUT). rem<=rem-step.
//   Transition to DONE on the edge where rem-step==0; RESULT<=new acc on same edge.
// - Passes: amount 1..7 -> 1; amount>=8 -> 2 (7 then 1, result 0x00).
//   Latency START-edge to DONE-high = passes+1 cycles (i.e. 2 or 3).
// - DONE: DONE=1 exactly one cycle; without new START return to IDLE, RESULT held.
// - Outside SHIFT: SH_IN=0, SH_CTRL=0 (barrel stage idle at zero).
// - rev() = bit reversal [7:0]->[0:7]; no arithmetic carries, no saturation beyond clamp.
// CONFIGURATION
// SHIFT_SEQ_ROR_EN defined: OPCODE=11 is rotate-right by k=AMOUNT[2:0].
//   k==0 -> passthrough, latency 1. Else exactly 2 passes:
//   pass A SH_IN=DATA, SH_CTRL=k, tmp<=SH_OUT; pass B SH_IN=rev(DATA), SH_CTRL=8-k,
//   RESULT<=tmp | rev(SH_OUT). Latency 3.
// SHIFT_SEQ_ROR_EN undefined: OPCODE=11 treated as reserved (passthrough, latency 1); no tmp reg.
// TESTING
// 1 SRL DATA=0x80 AMOUNT=4 -> one pass SH_CTRL=4, BUSY 1 cycle, DONE 2 cycles after START, RESULT=0x08
// 2 SLL DATA=0x01 AMOUNT=9 -> SH_CTRL 7 then 1, RESULT=0x00, DONE 3 cycles after START
// 3 SRL DATA=0xFF AMOUNT=0 -> no SHIFT, BUSY stays 0, DONE next cycle, RESULT=0xFF
// 4 SRL 0xF0 amt 8 started; START(SLL 0x01 amt 1) during BUSY ignored -> RESULT=0x00; then
//   START in DONE cycle with SLL 0x01 amt 1 accepted -> RESULT=0x02
// 5 SLL 0x01 amt 8, drive RESET low after first pass -> BUSY/DONE/RESULT/SH_* = 0 same cycle,
//   no DONE after release; next SRL 0x80 amt 7 -> RESULT=0x01
// 6 OPCODE=11 DATA=0x81 AMOUNT=1: with SHIFT_SEQ_ROR_EN -> SH_CTRL 1 then 7, RESULT=0xC0 latency 3;
//   without -> RESULT=0x81 latency 1

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Request/result and barrel-stage signals of the shift sequencer.
// The slave modport is the sequencer. The master modport is the ALU side plus the barrel stage.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 8
);
    logic             start;
    logic [1:0]       opcode;
    logic [WIDTH-1:0] data;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] sh_in;
    logic [2:0]       sh_ctrl;
    logic [WIDTH-1:0] sh_out;

    modport master (
        output start, opcode, data, amount, sh_out,
        input  busy, done, result, sh_in, sh_ctrl
    );
    modport slave (
        input  start, opcode, data, amount, sh_out,
        output busy, done, result, sh_in, sh_ctrl
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-pass SRL/SLL controller around an 8-bit logical-shift-right barrel stage.
// Define SHIFT_SEQ_ROR_EN to enable the two-pass rotate-right opcode (11).
module shift_sequencer #(
    parameter int WIDTH    = 8,
    parameter int AMT_W    = 8,
    parameter int STEP_MAX = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    state_t           state;
    logic [1:0]       op;
    logic [WIDTH-1:0] acc;
    logic [3:0]       rem;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q;
`ifdef SHIFT_SEQ_ROR_EN
    logic [WIDTH-1:0] tmp;
    logic             phase;
`endif

    logic [2:0]       step;
    logic [3:0]       rem_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] sh_in_c;
    logic [2:0]       sh_ctrl_c;
    logic [3:0]       amt_clamp;
    logic [3:0]       rem_init;
    logic             pass_thru;
    logic             accept;

    // SLL runs the right-shift stage on the bit-reversed operand
    always_comb begin
        step      = (rem > 4'(STEP_MAX)) ? 3'(STEP_MAX) : rem[2:0];
        rem_nxt   = rem - {1'b0, step};
        sh_in_c   = '0;
        sh_ctrl_c = '0;
        if (state == S_SHIFT) begin
            case (op)
                OP_SLL: begin
                    sh_in_c   = rev(acc);
                    sh_ctrl_c = step;
                end
`ifdef SHIFT_SEQ_ROR_EN
                OP_ROR: begin
                    sh_in_c   = phase ? rev(acc) : acc;
                    sh_ctrl_c = phase ? 3'(4'd8 - rem) : rem[2:0];
                end
`endif
                default: begin
                    sh_in_c   = acc;
                    sh_ctrl_c = step;
                end
            endcase
        end
        acc_nxt = (op == OP_SLL) ? rev(bus.sh_out) : bus.sh_out;
    end

    always_comb begin
        amt_clamp = (|bus.amount[AMT_W-1:3]) ? 4'd8 : {1'b0, bus.amount[2:0]};
        rem_init  = amt_clamp;
        pass_thru = (amt_clamp == 4'd0);
        case (bus.opcode)
            OP_RSV: pass_thru = 1'b1;
            OP_ROR: begin
`ifdef SHIFT_SEQ_ROR_EN
                rem_init  = {1'b0, bus.amount[2:0]};
                pass_thru = (bus.amount[2:0] == 3'd0);
`else
                pass_thru = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign accept = bus.start && (state != S_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op       <= OP_SRL;
            acc      <= '0;
            rem      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef SHIFT_SEQ_ROR_EN
            tmp      <= '0;
            phase    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                acc <= bus.data;
                op  <= bus.opcode;
                rem <= rem_init;
`ifdef SHIFT_SEQ_ROR_EN
                phase <= 1'b0;
`endif
                if (pass_thru) begin
                    result_q <= bus.data;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= S_DONE;
                end else begin
                    busy_q <= 1'b1;
                    state  <= S_SHIFT;
                end
            end else begin
                case (state)
                    S_SHIFT: begin
`ifdef SHIFT_SEQ_ROR_EN
                        if (op == OP_ROR) begin
                            // pass A keeps the low part, pass B adds the wrapped high part
                            if (!phase) begin
                                tmp   <= bus.sh_out;
                                phase <= 1'b1;
                            end else begin
                                result_q <= tmp | rev(bus.sh_out);
                                done_q   <= 1'b1;
                                busy_q   <= 1'b0;
                                state    <= S_DONE;
                            end
                        end else
`endif
                        begin
                            acc <= acc_nxt;
                            rem <= rem_nxt;
                            if (rem_nxt == 4'd0) begin
                                result_q <= acc_nxt;
                                done_q   <= 1'b1;
                                busy_q   <= 1'b0;
                                state    <= S_DONE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.sh_in   = sh_in_c;
    assign bus.sh_ctrl = sh_ctrl_c;
endmodule

// File: tb/tb_shift_sequencer.sv
// Randomised scoreboard bench for shift_sequencer with an 8-bit SRL barrel model.
// Honours SHIFT_SEQ_ROR_EN for the expected behaviour of opcode 11.
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_sequencer_if bus ();
    shift_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    assign bus.sh_out = bus.sh_in >> bus.sh_ctrl;

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         exp_ctrl[int];
    int         m_ctrl[$];
    int         cyc = 0;
    int         free_cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] held_res = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected result and per-pass shift amounts, straight from the shift definitions
    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] d,
                                         input logic [7:0] amt);
        int a;
        int k;
        logic [7:0] r;
        m_ctrl = {};
        a = (amt > 8) ? 8 : int'(amt);
        k = int'(amt) % 8;
        r = d;
        case (op)
            2'b00: r = 8'(int'(d) >> a);
            2'b01: r = 8'(int'(d) << a);
`ifdef SHIFT_SEQ_ROR_EN
            2'b11: if (k != 0) begin
                r = 8'((int'(d) >> k) | (int'(d) << (8 - k)));
                m_ctrl = {k, 8 - k};
            end
`endif
            default: r = d;
        endcase
        if (op[1] == 1'b0) begin
            if (a == 8) m_ctrl = {7, 1};
            else if (a > 0) m_ctrl = {a};
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a);
        exp_t e;
        bus.start  = 1'b1;
        bus.opcode = op;
        bus.data   = d;
        bus.amount = a;
        if (cyc >= free_cyc) begin
            e.res = model(op, d, a);
            foreach (m_ctrl[i]) exp_ctrl[cyc + 1 + i] = m_ctrl[i];
            e.cyc = cyc + m_ctrl.size() + 1;
            q.push_back(e);
            free_cyc = e.cyc;
        end
        @(negedge clk);
        #1;
        bus.start  = 1'b0;
        bus.opcode = 2'($urandom);
        bus.data   = 8'($urandom);
        bus.amount = 8'($urandom);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_result"}, bus.result, 0);
        check({tag, "_sh_in"}, bus.sh_in, 0);
        check({tag, "_sh_ctrl"}, bus.sh_ctrl, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("done_cycle", cyc, mon_e.cyc);
                    check("result", bus.result, mon_e.res);
                    held_res = mon_e.res;
                end
            end else begin
                check("result_hold", bus.result, held_res);
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    check("done_missing", 0, 1);
                    void'(q.pop_front());
                end
            end
            if (exp_ctrl.exists(cyc)) begin
                check("busy", bus.busy, 1);
                check("sh_ctrl", bus.sh_ctrl, exp_ctrl[cyc]);
                exp_ctrl.delete(cyc);
            end else begin
                check("busy_idle", bus.busy, 0);
                check("sh_ctrl_idle", bus.sh_ctrl, 0);
                check("sh_in_idle", bus.sh_in, 0);
            end
        end
    end

    initial begin
        int guard;
        bus.start  = 1'b0;
        bus.opcode = 2'b00;
        bus.data   = 8'h00;
        bus.amount = 8'h00;
        idle(2);
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);

        issue(2'b00, 8'h80, 8'd4);   idle(3);
        issue(2'b01, 8'h01, 8'd9);   idle(4);
        issue(2'b00, 8'hFF, 8'd0);   idle(2);
        // second request lands while busy, third lands in the DONE cycle
        issue(2'b00, 8'hF0, 8'd8);
        issue(2'b01, 8'h01, 8'd1);
        idle(1);
        issue(2'b01, 8'h01, 8'd1);   idle(3);

        // reset during the second pass of a two-pass SLL
        issue(2'b01, 8'h01, 8'd8);
        idle(1);
        rst_n = 1'b0;
        q.delete();
        exp_ctrl.delete();
        held_res = 8'h00;
        free_cyc = 0;
        #1;
        check_zero("midreset");
        idle(2);
        rst_n = 1'b1;
        idle(3);
        issue(2'b00, 8'h80, 8'd7);   idle(3);

        issue(2'b11, 8'h81, 8'd1);   idle(4);
        issue(2'b10, 8'h5A, 8'd3);   idle(2);

        repeat (300) begin
            logic [7:0] amt;
            amt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 9));
            issue(2'($urandom), 8'($urandom), amt);
            idle($urandom_range(0, 3));
        end

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        if (q.size() > 0) check("drain_timeout", q.size(), 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
